dsp_envelope: RTL and testbench

- Per-voice ADSR/GAIN envelope generator. It sits directly downstream of each voice's sample decoder and upstream of the L/R volume mixer.
- Once per output sample (32 kHz) it advances an 11-bit envelope and multiplies the decoded 16-bit voice sample by it.
- It produces the scaled sample plus the ENVX/OUTX register views.
- Eight instances are used, one per voice; each is ticked at that voice's slot in the 64-cycle schedule.

---
 rtl/dsp_envelope_pkg.sv | 88 ++++++++
 rtl/dsp_envelope_rate_counter.sv | 50 +++++
 rtl/dsp_envelope.sv | 170 +++++++++++++++++
 tb/tb_dsp_envelope.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_envelope_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_envelope_pkg
// Description : Shared types, constants and helper functions for the per-voice
//               ADSR/GAIN envelope generator.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_envelope_pkg;

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_e;

    localparam logic [10:0]        ENV_MAX          = 11'h7FF;
    localparam logic signed [12:0] ENV_MAX_S        = 13'sd2047;
    localparam logic signed [12:0] RELEASE_STEP     = 13'sd8;
    localparam logic signed [12:0] LINEAR_STEP      = 13'sd32;
    localparam logic signed [12:0] ATTACK_FAST_STEP = 13'sd1024;
    localparam logic signed [12:0] BENT_SLOW_STEP   = 13'sd8;
    localparam logic [10:0]        BENT_KNEE        = 11'h600;

    // Ticks between envelope steps for each 5-bit rate; 0 means "never".
    function automatic logic [11:0] rate_period(input logic [4:0] rate);
        logic [11:0] p;
        case (rate)
            5'd1:    p = 12'd2048;
            5'd2:    p = 12'd1536;
            5'd3:    p = 12'd1280;
            5'd4:    p = 12'd1024;
            5'd5:    p = 12'd768;
            5'd6:    p = 12'd640;
            5'd7:    p = 12'd512;
            5'd8:    p = 12'd384;
            5'd9:    p = 12'd320;
            5'd10:   p = 12'd256;
            5'd11:   p = 12'd192;
            5'd12:   p = 12'd160;
            5'd13:   p = 12'd128;
            5'd14:   p = 12'd96;
            5'd15:   p = 12'd80;
            5'd16:   p = 12'd64;
            5'd17:   p = 12'd48;
            5'd18:   p = 12'd40;
            5'd19:   p = 12'd32;
            5'd20:   p = 12'd24;
            5'd21:   p = 12'd20;
            5'd22:   p = 12'd16;
            5'd23:   p = 12'd12;
            5'd24:   p = 12'd10;
            5'd25:   p = 12'd8;
            5'd26:   p = 12'd6;
            5'd27:   p = 12'd5;
            5'd28:   p = 12'd4;
            5'd29:   p = 12'd3;
            5'd30:   p = 12'd2;
            5'd31:   p = 12'd1;
            default: p = 12'd0;
        endcase
        return p;
    endfunction

    // Saturate a signed intermediate into the 0..0x7FF envelope range.
    function automatic logic [10:0] env_clamp(input logic signed [12:0] v);
        logic [10:0] r;
        if (v < 13'sd0)
            r = 11'd0;
        else if (v > ENV_MAX_S)
            r = ENV_MAX;
        else
            r = v[10:0];
        return r;
    endfunction

    // Exponential decay amount: ((env-1)>>8)+1, forced to 0 at env=0.
    function automatic logic signed [12:0] exp_decrement(input logic [10:0] env);
        logic signed [12:0] r;
        if (env == 11'd0)
            r = 13'sd0;
        else
            r = $signed((({2'b00, env} - 13'd1) >> 8) + 13'd1);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_envelope_rate_counter.sv
`default_nettype none
// ============================================================================
// Module      : dsp_envelope_rate_counter
// Description : 11-bit tick down-counter producing an envelope step pulse
//               at the period selected by a 5-bit rate code.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_envelope_rate_counter
    import dsp_envelope_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [4:0] rate,
    input  logic       restart,
    output logic       step
);

    logic [10:0] cnt_q;
    logic [10:0] cnt_d;

    // Next count and step: step fires when a tick finds the counter at zero;
    // rate 0 freezes the counter and never steps.
    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (tick) begin
            if (restart) begin
                cnt_d = 11'd0;
            end else if (rate != 5'd0) begin
                if (cnt_q == 11'd0) begin
                    step  = 1'b1;
                    cnt_d = 11'(rate_period(rate) - 12'd1);
                end else begin
                    cnt_d = cnt_q - 11'd1;
                end
            end
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt_q <= 11'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/dsp_envelope.sv
`default_nettype none
// ============================================================================
// Module      : dsp_envelope
// Description : Per-voice ADSR/GAIN envelope generator. Advances an 11-bit
//               envelope once per sample tick and scales the voice sample.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_envelope
    import dsp_envelope_pkg::*;
#(
    parameter int ENV_BITS    = 11,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   key_on,
    input  logic                   key_off,
    input  logic [7:0]             adsr1,
    input  logic [7:0]             adsr2,
    input  logic [7:0]             gain,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic                   out_valid,
    output logic [ENV_BITS-1:0]    envelope,
    output logic [6:0]             envx,
    output logic [7:0]             outx,
    output logic [1:0]             state
);

    env_state_e                   state_q, state_d;
    logic [ENV_BITS-1:0]          env_q, env_d;
    logic                         pend_on_q, pend_on_d;
    logic                         pend_off_q, pend_off_d;
    logic [SAMPLE_BITS-1:0]       sample_out_q, sample_out_d;
    logic                         out_valid_q, out_valid_d;

    logic                         kon_eff;
    logic                         koff_eff;
    logic                         adsr_mode;
    logic [4:0]                   rate;
    logic                         restart;
    logic                         step;

    assign kon_eff   = pend_on_q  | key_on;
    assign koff_eff  = pend_off_q | key_off;
    assign adsr_mode = adsr1[7];
    assign restart   = sample_tick & kon_eff & ~koff_eff;

    // Rate selection for the current state/mode; RELEASE and direct GAIN
    // do not use the counter, so they select rate 0 and freeze it.
    always_comb begin
        rate = 5'd0;
        if (state_q != ST_RELEASE) begin
            if (adsr_mode) begin
                case (state_q)
                    ST_ATTACK:  rate = {adsr1[3:0], 1'b1};
                    ST_DECAY:   rate = {1'b1, adsr1[6:4], 1'b0};
                    ST_SUSTAIN: rate = adsr2[4:0];
                    default:    rate = 5'd0;
                endcase
            end else if (gain[7]) begin
                rate = gain[4:0];
            end
        end
    end

    dsp_envelope_rate_counter u_rate_counter (
        .clock   (clock),
        .reset   (reset),
        .tick    (sample_tick),
        .rate    (rate),
        .restart (restart),
        .step    (step)
    );

    // Envelope/state update, key flag bookkeeping and output scaling.
    // A key event consumes its tick: no envelope step happens on that tick.
    always_comb begin
        logic signed [12:0]                   env_s;
        logic signed [12:0]                   sum;
        logic [10:0]                          env_next;
        logic signed [SAMPLE_BITS+ENV_BITS:0] product;

        state_d      = state_q;
        env_d        = env_q;
        pend_on_d    = kon_eff;
        pend_off_d   = koff_eff;
        sample_out_d = sample_out_q;
        out_valid_d  = sample_tick;
        env_s        = $signed({2'b00, env_q});
        sum          = env_s;
        env_next     = env_q;
        product      = '0;

        if (sample_tick) begin
            pend_on_d  = 1'b0;
            pend_off_d = 1'b0;
            if (koff_eff) begin
                state_d = ST_RELEASE;
            end else if (kon_eff) begin
                env_d   = '0;
                state_d = ST_ATTACK;
            end else if (state_q == ST_RELEASE) begin
                env_d = env_clamp(env_s - RELEASE_STEP);
            end else if (adsr_mode) begin
                if (step) begin
                    case (state_q)
                        ST_ATTACK: begin
                            sum   = env_s + ((rate == 5'd31) ? ATTACK_FAST_STEP : LINEAR_STEP);
                            env_d = env_clamp(sum);
                            if (sum > ENV_MAX_S)
                                state_d = ST_DECAY;
                        end
                        ST_DECAY: begin
                            env_next = env_clamp(env_s - exp_decrement(env_q));
                            env_d    = env_next;
                            if (env_next[10:8] == adsr2[7:5])
                                state_d = ST_SUSTAIN;
                        end
                        default: begin
                            env_d = env_clamp(env_s - exp_decrement(env_q));
                        end
                    endcase
                end
            end else if (!gain[7]) begin
                env_d = {gain[6:0], 4'b0000};
            end else if (step) begin
                case (gain[6:5])
                    2'd0:    sum = env_s - LINEAR_STEP;
                    2'd1:    sum = env_s - exp_decrement(env_q);
                    2'd2:    sum = env_s + LINEAR_STEP;
                    default: sum = env_s + ((env_q < BENT_KNEE) ? LINEAR_STEP : BENT_SLOW_STEP);
                endcase
                env_d = env_clamp(sum);
            end

            product      = $signed(sample_in) * $signed({1'b0, env_d});
            sample_out_d = SAMPLE_BITS'(product >>> ENV_BITS);
        end
    end

    // State, envelope, key flag and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RELEASE;
            env_q        <= '0;
            pend_on_q    <= 1'b0;
            pend_off_q   <= 1'b0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            env_q        <= env_d;
            pend_on_q    <= pend_on_d;
            pend_off_q   <= pend_off_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign envelope   = env_q;
    assign envx       = env_q[ENV_BITS-1 -: 7];
    assign outx       = sample_out_q[SAMPLE_BITS-1 -: 8];
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_envelope.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_envelope
// Description : Directed self-checking bench for dsp_envelope.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_envelope;

    logic        clock;
    logic        reset;
    logic        sample_tick;
    logic        key_on;
    logic        key_off;
    logic [7:0]  adsr1;
    logic [7:0]  adsr2;
    logic [7:0]  gain;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic        out_valid;
    logic [10:0] envelope;
    logic [6:0]  envx;
    logic [7:0]  outx;
    logic [1:0]  state;

    int checks;
    int failures;

    dsp_envelope dut (
        .clock       (clock),
        .reset       (reset),
        .sample_tick (sample_tick),
        .key_on      (key_on),
        .key_off     (key_off),
        .adsr1       (adsr1),
        .adsr2       (adsr2),
        .gain        (gain),
        .sample_in   (sample_in),
        .sample_out  (sample_out),
        .out_valid   (out_valid),
        .envelope    (envelope),
        .envx        (envx),
        .outx        (outx),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One tick; returns at the negedge after the sampling posedge.
    task automatic do_tick();
        @(negedge clock);
        sample_tick = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
    endtask

    task automatic pulse_keys(input logic on, input logic off);
        @(negedge clock);
        key_on  = on;
        key_off = off;
        @(negedge clock);
        key_on  = 1'b0;
        key_off = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (envelope !== 11'h000 || state !== 2'd3 || sample_out !== 16'h0000 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset: env=%h state=%0d out=%h valid=%b, want 000/3/0000/0", envelope, state, sample_out, out_valid);
        end
    endtask

    task automatic test_gain_direct();
        adsr1 = 8'h00; gain = 8'h7F; sample_in = 16'h4000;
        pulse_keys(1'b1, 1'b0);
        do_tick();
        checks++;
        if (envelope !== 11'h000 || state !== 2'd0) begin
            failures++;
            $display("FAIL gain_keyon: env=%h state=%0d, want 000/0", envelope, state);
        end
        do_tick();
        checks++;
        if (envelope !== 11'h7F0 || envx !== 7'h7F) begin
            failures++;
            $display("FAIL gain_direct_env: env=%h envx=%h, want 7f0/7f", envelope, envx);
        end
        checks++;
        if (sample_out !== 16'h3F80 || outx !== 8'h3F || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL gain_direct_out: out=%h outx=%h valid=%b, want 3f80/3f/1", sample_out, outx, out_valid);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_pulse: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_adsr();
        adsr1 = 8'hFF; adsr2 = 8'hE0; sample_in = 16'h8000;
        pulse_keys(1'b1, 1'b0);
        do_tick();
        checks++;
        if (envelope !== 11'h000 || state !== 2'd0) begin
            failures++;
            $display("FAIL adsr_t1: env=%h state=%0d, want 000/0", envelope, state);
        end
        do_tick();
        checks++;
        if (envelope !== 11'h400 || state !== 2'd0) begin
            failures++;
            $display("FAIL adsr_t2: env=%h state=%0d, want 400/0", envelope, state);
        end
        do_tick();
        checks++;
        if (envelope !== 11'h7FF || state !== 2'd1) begin
            failures++;
            $display("FAIL adsr_t3: env=%h state=%0d, want 7ff/1", envelope, state);
        end
        do_tick();
        checks++;
        if (envelope !== 11'h7F7 || state !== 2'd2) begin
            failures++;
            $display("FAIL adsr_decay: env=%h state=%0d, want 7f7/2", envelope, state);
        end
        checks++;
        if (sample_out !== 16'h8090) begin
            failures++;
            $display("FAIL adsr_neg_out: out=%h, want 8090", sample_out);
        end
        do_tick();
        checks++;
        if (envelope !== 11'h7F7 || state !== 2'd2) begin
            failures++;
            $display("FAIL sustain_sr0: env=%h state=%0d, want 7f7/2", envelope, state);
        end
    endtask

    task automatic test_release();
        logic [10:0] exp_env;
        adsr1 = 8'h00; gain = 8'h10;
        do_tick();
        checks++;
        if (envelope !== 11'h100 || state !== 2'd2) begin
            failures++;
            $display("FAIL rel_setup: env=%h state=%0d, want 100/2", envelope, state);
        end
        pulse_keys(1'b0, 1'b1);
        do_tick();
        checks++;
        if (envelope !== 11'h100 || state !== 2'd3) begin
            failures++;
            $display("FAIL rel_keyoff: env=%h state=%0d, want 100/3", envelope, state);
        end
        exp_env = 11'h100;
        for (int i = 0; i < 33; i++) begin
            do_tick();
            exp_env = (exp_env >= 11'd8) ? exp_env - 11'd8 : 11'd0;
            checks++;
            if (envelope !== exp_env || state !== 2'd3) begin
                failures++;
                $display("FAIL rel_step%0d: env=%h state=%0d, want %h/3", i, envelope, state, exp_env);
            end
        end
    endtask

    task automatic test_key_both();
        pulse_keys(1'b1, 1'b0);
        do_tick();
        gain = 8'h20;
        do_tick();
        checks++;
        if (envelope !== 11'h200 || state !== 2'd0) begin
            failures++;
            $display("FAIL both_setup: env=%h state=%0d, want 200/0", envelope, state);
        end
        pulse_keys(1'b1, 1'b1);
        do_tick();
        checks++;
        if (envelope !== 11'h200 || state !== 2'd3) begin
            failures++;
            $display("FAIL both_keys: env=%h state=%0d, want 200/3", envelope, state);
        end
        pulse_keys(1'b1, 1'b0);
        do_tick();
        checks++;
        if (envelope !== 11'h000 || state !== 2'd0) begin
            failures++;
            $display("FAIL keyon_alone: env=%h state=%0d, want 000/0", envelope, state);
        end
    endtask

    task automatic test_back_to_back();
        gain = 8'h30;
        do_tick();
        @(negedge clock);
        sample_tick = 1'b1; key_off = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0; key_off = 1'b0;
        checks++;
        if (envelope !== 11'h300 || state !== 2'd3) begin
            failures++;
            $display("FAIL coincident_off: env=%h state=%0d, want 300/3", envelope, state);
        end
        @(negedge clock);
        sample_tick = 1'b1; key_on = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0; key_on = 1'b0;
        checks++;
        if (envelope !== 11'h000 || state !== 2'd0) begin
            failures++;
            $display("FAIL coincident_on: env=%h state=%0d, want 000/0", envelope, state);
        end
    endtask

    task automatic test_gain_bent();
        logic [11:0] exp_env;
        gain = 8'hFF; adsr1 = 8'h00;
        exp_env = 12'd0;
        for (int i = 0; i < 114; i++) begin
            do_tick();
            exp_env = exp_env + ((exp_env < 12'h600) ? 12'd32 : 12'd8);
            if (exp_env > 12'h7FF) exp_env = 12'h7FF;
            checks++;
            if ({1'b0, envelope} !== exp_env || state !== 2'd0) begin
                failures++;
                $display("FAIL bent_step%0d: env=%h state=%0d, want %h/0", i, envelope, state, exp_env);
            end
        end
    endtask

    task automatic test_async_reset();
        adsr1 = 8'hFF; adsr2 = 8'hE0; sample_in = 16'h4000;
        pulse_keys(1'b1, 1'b0);
        do_tick();
        do_tick();
        checks++;
        if (envelope !== 11'h400 || state !== 2'd0 || sample_out !== 16'h2000) begin
            failures++;
            $display("FAIL areset_setup: env=%h state=%0d out=%h, want 400/0/2000", envelope, state, sample_out);
        end
        pulse_keys(1'b1, 1'b0);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (envelope !== 11'h000 || state !== 2'd3 || sample_out !== 16'h0000) begin
            failures++;
            $display("FAIL areset_immediate: env=%h state=%0d out=%h, want 000/3/0000", envelope, state, sample_out);
        end
        @(negedge clock);
        reset = 1'b1;
        do_tick();
        checks++;
        if (envelope !== 11'h000 || state !== 2'd3) begin
            failures++;
            $display("FAIL areset_pending_cleared: env=%h state=%0d, want 000/3", envelope, state);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; sample_tick = 1'b0; key_on = 1'b0; key_off = 1'b0;
        adsr1 = 8'h00; adsr2 = 8'h00; gain = 8'h00; sample_in = 16'h0000;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b1;
        test_gain_direct();
        test_adsr();
        test_release();
        test_key_both();
        test_back_to_back();
        test_gain_bent();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
